uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_rx_cfg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  // Parity mode selected at elaboration time
  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_t;

  // Receiver sampling FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  // Returns 1 when the received parity bit disagrees with the selected mode
  function automatic logic parity_bad(input parity_t mode, input logic data_xor,
                                      input logic par_bit);
    logic bad;
    bad = 1'b0;
    case (mode)
      EVEN:    bad = data_xor ^ par_bit;
      ODD:     bad = ~(data_xor ^ par_bit);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO holding received words.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push_c;
  logic             do_pop_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, baud/bit counters, sampling FSM,
// sticky error flags and a small FWFT buffer of received words.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BAUD_DIV   = 2604,
  parameter parity_t     PARITY     = NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  output logic              frm_err,
  output logic              par_err,
  output logic              ovr_err
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  // Reject illegal configurations at elaboration
  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_rx_cfg: DATA_W must be 5..9");
    end
    if (BAUD_DIV < 16) begin : g_bad_baud
      $error("uart_rx_cfg: BAUD_DIV must be >= 16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic              rx_s1;
  logic              rx_s2;
  logic              rx_prev;
  logic [CNT_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bad;
  logic              stop_bad;
  logic              fifo_full;
  logic              fifo_empty;

  logic fall_c;
  logic tick_c;
  logic last_data_c;
  logic last_stop_c;
  logic done_c;
  logic frm_bad_c;
  logic par_bad_c;
  logic push_c;
  logic pop_c;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall_c      = rx_prev & ~rx_s2;
  assign tick_c      = (state != IDLE) && (baud_cnt == '0);
  assign last_data_c = (bit_cnt == BIT_W'(DATA_W - 1));
  assign last_stop_c = (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign done_c      = tick_c && (state == STOP) && last_stop_c;
  assign frm_bad_c   = stop_bad | ~rx_s2;
  assign par_bad_c   = parity_bad(PARITY, ^shreg, rx_s2);
  assign push_c      = done_c & ~frm_bad_c & ~par_bad;
  assign pop_c       = rd_en & rdy;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; every transition outside IDLE waits for a sample strobe
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (fall_c) state_nxt = START;
      START: if (tick_c) state_nxt = rx_s2 ? IDLE : DATA;
      DATA:  if (tick_c && last_data_c) state_nxt = (PARITY != NONE) ? PAR : STOP;
      PAR:   if (tick_c) state_nxt = STOP;
      STOP:  if (tick_c && last_stop_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter: half-bit load on start edge centres later samples mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= fall_c ? CNT_W'(BAUD_DIV / 2 - 1) : '0;
    end else if (baud_cnt == '0) begin
      baud_cnt <= CNT_W'(BAUD_DIV - 1);
    end else begin
      baud_cnt <= baud_cnt - CNT_W'(1);
    end
  end

  // Per-sample datapath: bit counter, LSB-first shifter, parity and stop checks
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else if (tick_c) begin
      case (state)
        START: begin
          bit_cnt  <= '0;
          par_bad  <= 1'b0;
          stop_bad <= 1'b0;
        end
        DATA: begin
          shreg   <= {rx_s2, shreg[DATA_W-1:1]};
          bit_cnt <= last_data_c ? '0 : bit_cnt + BIT_W'(1);
        end
        PAR: begin
          par_bad <= par_bad_c;
        end
        STOP: begin
          stop_bad <= stop_bad | ~rx_s2;
          bit_cnt  <= last_stop_c ? '0 : bit_cnt + BIT_W'(1);
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_err <= 1'b0;
      par_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      frm_err <= (done_c & frm_bad_c) | (frm_err & ~clr_err);
      par_err <= (done_c & par_bad) | (par_err & ~clr_err);
      ovr_err <= (push_c & fifo_full & ~pop_c) | (ovr_err & ~clr_err);
    end
  end

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (shreg),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rdy = ~fifo_empty;

endmodule
